// File: rtl/audio_pkg.sv
// Shared audio-path constants: envelope state encodings and full-scale level helper.
package audio_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ATTACK  = 3'd1;
  localparam logic [2:0] ST_DECAY   = 3'd2;
  localparam logic [2:0] ST_SUSTAIN = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  typedef logic [2:0] env_state_t;

  // Largest positive value of a signed word of the given width (unity gain downstream).
  function automatic int env_max(input int bitsize);
    return (1 << (bitsize - 1)) - 1;
  endfunction

endpackage

// File: rtl/env_sat_step.sv
// One saturating envelope step: moves level toward bound by step, never past it.
module env_sat_step #(
  parameter int W = 15
) (
  input  logic [W-1:0] level,
  input  logic [W-1:0] step,
  input  logic         dir,
  input  logic [W-1:0] bound,
  output logic [W-1:0] next_level,
  output logic         reached
);

  logic [W:0] wide;

  // One extra bit catches both carry-out on the way up and borrow on the way down;
  // a zero step means jump straight to the bound.
  always_comb begin
    wide       = '0;
    next_level = bound;
    reached    = 1'b1;
    if (dir) begin
      wide = {1'b0, level} + {1'b0, step};
      if (step != '0 && wide < {1'b0, bound}) begin
        next_level = wide[W-1:0];
        reached    = 1'b0;
      end
    end else begin
      wide = {1'b0, level} - {1'b0, step};
      if (step != '0 && !wide[W] && wide[W-1:0] > bound) begin
        next_level = wide[W-1:0];
        reached    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope; gate edges act at clock rate, level moves on sample ticks.
module adsr_envelope
  import audio_pkg::*;
#(
  parameter int BITSIZE = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_tick,
  input  logic               gate,
  input  logic [BITSIZE-2:0] attack_step,
  input  logic [BITSIZE-2:0] decay_step,
  input  logic [BITSIZE-2:0] sustain_level,
  input  logic [BITSIZE-2:0] release_step,
  output logic [BITSIZE-1:0] out,
  output logic [2:0]         state,
  output logic               active
);

  localparam int LW = BITSIZE - 1;
  localparam logic [LW-1:0] LVL_MAX = LW'(env_max(BITSIZE));

  logic [LW-1:0] level;
  logic          gate_d;
  logic          rise, fall;
  logic [LW-1:0] st_step, st_bound, st_next;
  logic          st_dir, st_reached;

  assign rise = gate & ~gate_d;
  assign fall = ~gate & gate_d;

  always_comb begin
    st_step  = '0;
    st_bound = '0;
    st_dir   = 1'b0;
    case (state)
      ST_ATTACK: begin
        st_step  = attack_step;
        st_bound = LVL_MAX;
        st_dir   = 1'b1;
      end
      ST_DECAY: begin
        st_step  = decay_step;
        st_bound = sustain_level;
      end
      ST_RELEASE: st_step = release_step;
      default: ;
    endcase
  end

  env_sat_step #(.W(LW)) u_step (
    .level      (level),
    .step       (st_step),
    .dir        (st_dir),
    .bound      (st_bound),
    .next_level (st_next),
    .reached    (st_reached)
  );

  // Any gate edge wins the cycle: state moves, level holds, a coincident tick is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      level  <= '0;
      state  <= ST_IDLE;
      gate_d <= 1'b0;
    end else begin
      gate_d <= gate;
      if (rise) begin
        state <= ST_ATTACK;
      end else if (fall) begin
        if (state == ST_ATTACK || state == ST_DECAY || state == ST_SUSTAIN)
          state <= ST_RELEASE;
      end else if (sample_tick) begin
        case (state)
          ST_ATTACK: begin
            level <= st_next;
            if (st_reached) state <= ST_DECAY;
          end
          ST_DECAY: begin
            level <= st_next;
            if (st_reached) state <= ST_SUSTAIN;
          end
          ST_SUSTAIN: level <= sustain_level;
          ST_RELEASE: begin
            level <= st_next;
            if (st_reached) state <= ST_IDLE;
          end
          default: begin
            level <= '0;
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign out    = {1'b0, level};
  assign active = (state != ST_IDLE);

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope: walks the full ADSR cycle, retrigger and edge cases.
module tb_adsr_envelope;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_tick;
  logic        gate;
  logic [14:0] attack_step, decay_step, sustain_level, release_step;
  logic [15:0] out;
  logic [2:0]  state;
  logic        active;

  int n_cmp = 0;
  int n_err = 0;

  adsr_envelope #(.BITSIZE(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .sample_tick   (sample_tick),
    .gate          (gate),
    .attack_step   (attack_step),
    .decay_step    (decay_step),
    .sustain_level (sustain_level),
    .release_step  (release_step),
    .out           (out),
    .state         (state),
    .active        (active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] e_out, input logic [2:0] e_st);
    chk({tag, ".out"}, out, e_out);
    chk({tag, ".state"}, {13'd0, state}, {13'd0, e_st});
    chk({tag, ".active"}, {15'd0, active}, {15'd0, e_st != 3'd0});
  endtask

  // One clock with the given tick level; inputs change and outputs are sampled on negedge.
  task automatic cyc(input logic tk);
    sample_tick = tk;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  initial begin
    rst = 1'b1; gate = 1'b1; sample_tick = 1'b1;
    attack_step = 15'h1000; decay_step = 15'h2000;
    sustain_level = 15'h4000; release_step = 15'h3000;
    repeat (3) @(negedge clk);
    chk_all("reset", 16'h0000, 3'd0);

    // First clock out of reset sees the gate rise
    rst = 1'b0;
    cyc(1'b0);
    chk_all("rise_after_reset", 16'h0000, 3'd1);

    for (int i = 1; i <= 7; i++) begin
      cyc(1'b1);
      chk_all($sformatf("attack%0d", i), 16'(i * 16'h1000), 3'd1);
    end
    cyc(1'b1);
    chk_all("attack_sat", 16'h7FFF, 3'd2);

    cyc(1'b0);
    chk_all("no_tick_frozen", 16'h7FFF, 3'd2);

    cyc(1'b1);
    chk_all("decay1", 16'h5FFF, 3'd2);
    cyc(1'b1);
    chk_all("decay_clamp", 16'h4000, 3'd3);

    sustain_level = 15'h3000;
    cyc(1'b1);
    chk_all("sustain_track", 16'h3000, 3'd3);
    sustain_level = 15'h4000;
    cyc(1'b1);
    chk_all("sustain_back", 16'h4000, 3'd3);

    gate = 1'b0;
    cyc(1'b1);
    chk_all("fall_with_tick", 16'h4000, 3'd4);
    cyc(1'b1);
    chk_all("release1", 16'h1000, 3'd4);
    cyc(1'b1);
    chk_all("release_zero", 16'h0000, 3'd0);

    // Climb back to 0x1000 then drop into RELEASE there
    gate = 1'b1;
    cyc(1'b0);
    chk_all("rise_idle", 16'h0000, 3'd1);
    cyc(1'b1);
    chk_all("reattack1", 16'h1000, 3'd1);
    gate = 1'b0;
    cyc(1'b0);
    chk_all("fall_attack", 16'h1000, 3'd4);

    gate = 1'b1;
    cyc(1'b1);
    chk_all("retrig_with_tick", 16'h1000, 3'd1);
    cyc(1'b1);
    chk_all("retrig_step", 16'h2000, 3'd1);

    attack_step = 15'h0000;
    cyc(1'b1);
    chk_all("attack_instant", 16'h7FFF, 3'd2);

    // Re-enter ATTACK at 0x7FFF, then reset aborts with no tail
    gate = 1'b0;
    cyc(1'b0);
    gate = 1'b1;
    cyc(1'b0);
    chk_all("retrig_decay", 16'h7FFF, 3'd1);
    rst = 1'b1;
    cyc(1'b1);
    chk_all("reset_mid_attack", 16'h0000, 3'd0);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
